// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl_pkg
// Description : Shared definitions for the decode-stage hazard / stall
//               controller: register-index width, branch command encodings,
//               sequencing FSM state encodings and a small helper function.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_stall_ctrl_pkg;

    // Width of a register index (instr[20:16] style 5-bit field).
    localparam int REG_LENGTH = 5;

    // Decode-stage branch command encodings. BR_NONE means "not a branch";
    // every other value is a branch that compares register values in decode.
    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_BEZ  = 2'd1;
    localparam logic [1:0] BR_BNE  = 2'd2;
    localparam logic [1:0] BR_JMP  = 2'd3;

    // Memory-sequencing FSM states.
    typedef enum logic [1:0] {
        HSC_RUN      = 2'd0,
        HSC_MEM_WAIT = 2'd1,
        HSC_TIMEOUT  = 2'd2
    } hsc_state_e;

    // src2 is read by register-register ops, and by stores / BNE even though
    // those also carry an immediate.
    function automatic logic src2_is_used(input logic is_imm,
                                          input logic st_or_bne);
        return (!is_imm) || st_or_bne;
    endfunction

endpackage : hazard_stall_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_stall_ctrl_reg_match_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl_reg_match_unit
// Description : Combinational comparator between the decode-stage source
//               registers and one in-flight destination register. One
//               instance per compared pipeline stage.
// Ports       : src1_i      - decode source 1 index (always used)
//               src2_i      - decode source 2 index
//               src2_used_i - source 2 is actually read by the instruction
//               dest_i      - destination index of the compared stage
//               dest_en_i   - qualifier for the destination (e.g. wb enable)
//               match_o     - a used source matches a live destination
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl_reg_match_unit
    import hazard_stall_ctrl_pkg::*;
(
    input  logic [REG_LENGTH-1:0] src1_i,
    input  logic [REG_LENGTH-1:0] src2_i,
    input  logic                  src2_used_i,
    input  logic [REG_LENGTH-1:0] dest_i,
    input  logic                  dest_en_i,
    output logic                  match_o
);

    logic w_dest_live;
    logic w_src1_hit;
    logic w_src2_hit;

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    assign w_dest_live = dest_en_i && (dest_i != '0);
    assign w_src1_hit  = (src1_i == dest_i);
    assign w_src2_hit  = src2_used_i && (src2_i == dest_i);
    assign match_o     = w_dest_live && (w_src1_hit || w_src2_hit);

endmodule : hazard_stall_ctrl_reg_match_unit
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Decode-stage pipeline sequencing controller. Detects RAW
//               hazards against the EXE/MEM stages, freezes the front end,
//               flushes IF/ID on taken branches, holds the whole pipe while
//               data memory is busy, and raises a sticky timeout if memory
//               never answers. Saturating counters give debug visibility.
//
// Build option: HAZARD_FORWARDING_EN
//               defined   - forwarding-aware rules: only load-use hazards,
//                           plus branch-operand hazards on EXE (branches
//                           compare in decode and cannot use forwarding)
//               undefined - full EXE/MEM RAW stall, no forwarding assumed
//
// Parameters  : MEM_TIMEOUT - consecutive memory-wait cycles before TIMEOUT
//               CNT_W       - width of the performance counters
// Ports       : clk, reset (synchronous, active-low)
//               source1, src2_reg_file, is_imm, st_or_bne, branch_comm,
//               br_taken                 - decode-stage inputs
//               exe_dest, exe_wb_en, exe_mem_read - EXE-stage destination
//               mem_dest, mem_wb_en      - MEM-stage destination
//               mem_req, mem_ready       - data memory handshake
//               hazard_detected          - bubble request to decode control
//               freeze_front             - hold PC and IF/ID
//               flush_ifid               - load NOP into IF/ID next edge
//               freeze_all               - hold every pipeline register
//               mem_timeout              - sticky memory timeout flag
//               stall_cycles, flush_count - saturating debug counters
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_LENGTH-1:0] source1,
    input  logic [REG_LENGTH-1:0] src2_reg_file,
    input  logic                  is_imm,
    input  logic                  st_or_bne,
    input  logic [1:0]            branch_comm,
    input  logic                  br_taken,
    input  logic [REG_LENGTH-1:0] exe_dest,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_read,
    input  logic [REG_LENGTH-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  hazard_detected,
    output logic                  freeze_front,
    output logic                  flush_ifid,
    output logic                  freeze_all,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    // The wait counter only has to reach MEM_TIMEOUT-1.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] c_WAIT_ONE  = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  c_CNT_ONE   = CNT_W'(1);

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic w_src2_used;
    logic w_exe_en;
    logic w_exe_match;
    logic w_hazard_raw;

    assign w_src2_used = src2_is_used(is_imm, st_or_bne);

    hazard_stall_ctrl_reg_match_unit u_exe_match (
        .src1_i      (source1),
        .src2_i      (src2_reg_file),
        .src2_used_i (w_src2_used),
        .dest_i      (exe_dest),
        .dest_en_i   (w_exe_en),
        .match_o     (w_exe_match)
    );

`ifdef HAZARD_FORWARDING_EN
    // With forwarding, an EXE result is usable next cycle unless it is a
    // load (data not yet available) or the consumer is a branch, which
    // reads register values directly in decode. MEM results are always
    // forwardable, so the MEM stage is not compared at all.
    logic w_unused_mem;

    assign w_exe_en     = exe_mem_read ||
                          ((branch_comm != BR_NONE) && exe_wb_en);
    assign w_hazard_raw = w_exe_match;
    assign w_unused_mem = ^{mem_dest, mem_wb_en};
`else
    // Without forwarding, any pending write in EXE or MEM must retire first.
    logic w_mem_match;
    logic w_unused_fwd;

    hazard_stall_ctrl_reg_match_unit u_mem_match (
        .src1_i      (source1),
        .src2_i      (src2_reg_file),
        .src2_used_i (w_src2_used),
        .dest_i      (mem_dest),
        .dest_en_i   (mem_wb_en),
        .match_o     (w_mem_match)
    );

    assign w_exe_en     = exe_wb_en;
    assign w_hazard_raw = w_exe_match || w_mem_match;
    assign w_unused_fwd = ^{exe_mem_read, branch_comm};
`endif

    // ------------------------------------------------------------------
    // Memory sequencing FSM
    // ------------------------------------------------------------------
    hsc_state_e        state_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] w_wait_inc;
    logic              mem_timeout_q;

    assign w_wait_inc = wait_cnt_q + c_WAIT_ONE;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= HSC_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                HSC_RUN: begin
                    if (mem_req && !mem_ready) begin
                        state_q    <= HSC_MEM_WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                HSC_MEM_WAIT: begin
                    // A late mem_ready wins even on the limit cycle.
                    if (mem_ready) begin
                        state_q <= HSC_RUN;
                    end else begin
                        wait_cnt_q <= w_wait_inc;
                        if (w_wait_inc >= c_WAIT_LAST) begin
                            state_q       <= HSC_TIMEOUT;
                            mem_timeout_q <= 1'b1;
                        end
                    end
                end
                HSC_TIMEOUT: begin
                    // Terminal until reset.
                    mem_timeout_q <= 1'b1;
                end
                default: begin
                    state_q <= HSC_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pipeline control outputs (combinational, zero latency)
    // ------------------------------------------------------------------
    // The freeze is driven straight from the handshake so that the first
    // wait cycle already holds the pipe, before the FSM leaves RUN.
    assign freeze_all      = (mem_req && !mem_ready) || (state_q == HSC_TIMEOUT);

    // A full freeze holds every stage, so no bubble or flush is needed.
    assign hazard_detected = w_hazard_raw && !freeze_all;
    assign freeze_front    = hazard_detected;
    // A stalled branch re-resolves next cycle; flushing now would drop it.
    assign flush_ifid      = br_taken && !freeze_all && !hazard_detected;
    assign mem_timeout     = mem_timeout_q;

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((hazard_detected || freeze_all) && (stall_cnt_q != c_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + c_CNT_ONE;
        end
        if (flush_ifid && (flush_cnt_q != c_CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule : hazard_stall_ctrl
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Self-checking bench for hazard_stall_ctrl. Directed cases
//               for the documented scenarios, then randomized traffic
//               compared every cycle against a behavioural model that
//               tracks memory-wait episodes by length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;
    import hazard_stall_ctrl_pkg::*;

    localparam int MT   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [REG_LENGTH-1:0] source1, src2_reg_file, exe_dest, mem_dest;
    logic                  is_imm, st_or_bne, br_taken;
    logic [1:0]            branch_comm;
    logic                  exe_wb_en, exe_mem_read, mem_wb_en;
    logic                  mem_req, mem_ready;
    logic                  hazard_detected, freeze_front, flush_ifid;
    logic                  freeze_all, mem_timeout;
    logic [CW-1:0]         stall_cycles, flush_count;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(
        .MEM_TIMEOUT (MT),
        .CNT_W       (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .source1         (source1),
        .src2_reg_file   (src2_reg_file),
        .is_imm          (is_imm),
        .st_or_bne       (st_or_bne),
        .branch_comm     (branch_comm),
        .br_taken        (br_taken),
        .exe_dest        (exe_dest),
        .exe_wb_en       (exe_wb_en),
        .exe_mem_read    (exe_mem_read),
        .mem_dest        (mem_dest),
        .mem_wb_en       (mem_wb_en),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .hazard_detected (hazard_detected),
        .freeze_front    (freeze_front),
        .flush_ifid      (flush_ifid),
        .freeze_all      (freeze_all),
        .mem_timeout     (mem_timeout),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_in_wait;     // inside a memory-wait episode
    int m_waited;      // cycles elapsed in the current episode
    bit m_timed_out;
    int m_stall;
    int m_flush;

    task automatic model_reset();
        m_in_wait   = 1'b0;
        m_waited    = 0;
        m_timed_out = 1'b0;
        m_stall     = 0;
        m_flush     = 0;
    endtask

    function automatic bit reads(input logic [REG_LENGTH-1:0] r);
        return (r != 0) && ((source1 == r) ||
                            ((!is_imm || st_or_bne) && (src2_reg_file == r)));
    endfunction

    function automatic bit m_raw();
`ifdef HAZARD_FORWARDING_EN
        return reads(exe_dest) &&
               (exe_mem_read || ((branch_comm != 2'd0) && exe_wb_en));
`else
        return (exe_wb_en && reads(exe_dest)) || (mem_wb_en && reads(mem_dest));
`endif
    endfunction

    // One clock: check all outputs mid-cycle, then advance the model on the
    // rising edge using the inputs that the DUT sampled there.
    task automatic cycle();
        bit fa, hz, fl;
        @(negedge clk);
        fa = (mem_req && !mem_ready) || m_timed_out;
        hz = m_raw() && !fa;
        fl = br_taken && !fa && !hz;
        check("hazard_detected", hazard_detected, hz);
        check("freeze_front", freeze_front, hz);
        check("flush_ifid", flush_ifid, fl);
        check("freeze_all", freeze_all, fa);
        check("mem_timeout", mem_timeout, m_timed_out);
        check("stall_cycles", stall_cycles, m_stall);
        check("flush_count", flush_count, m_flush);
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            if ((hz || fa) && m_stall < CMAX) m_stall++;
            if (fl && m_flush < CMAX) m_flush++;
            if (!m_timed_out) begin
                if (m_in_wait) begin
                    if (mem_ready) m_in_wait = 1'b0;
                    else           m_waited++;
                end else if (mem_req && !mem_ready) begin
                    m_in_wait = 1'b1;
                    m_waited  = 1;
                end
                if (m_in_wait && m_waited >= MT) m_timed_out = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle();
        source1 = '0; src2_reg_file = '0; is_imm = 1'b0; st_or_bne = 1'b0;
        branch_comm = 2'd0; br_taken = 1'b0;
        exe_dest = '0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
        mem_dest = '0; mem_wb_en = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic reset_cycle();
        idle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b1;

        // Reset values
        check("rst_hazard", hazard_detected, 0);
        check("rst_freeze_front", freeze_front, 0);
        check("rst_flush", flush_ifid, 0);
        check("rst_freeze_all", freeze_all, 0);
        check("rst_timeout", mem_timeout, 0);
        check("rst_stall_cnt", stall_cycles, 0);
        check("rst_flush_cnt", flush_count, 0);

        // Load-use on r5 (a load also writes back)
        exe_dest = 5'd5; exe_wb_en = 1'b1; exe_mem_read = 1'b1; source1 = 5'd5;
        #1;
        check("loaduse_hazard", hazard_detected, 1);
        check("loaduse_freeze_front", freeze_front, 1);
        cycle();
        exe_dest = '0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
        mem_dest = 5'd5; mem_wb_en = 1'b1;
        #1;
`ifdef HAZARD_FORWARDING_EN
        check("loaduse_released", hazard_detected, 0);
        cycle();
        check("loaduse_stall_cnt", stall_cycles, 1);
`else
        check("raw_mem_hazard", hazard_detected, 1);
        cycle();
        check("raw_stall_cnt", stall_cycles, 2);
`endif

        // Immediate form: src2 not read
        idle();
        is_imm = 1'b1; src2_reg_file = 5'd7; source1 = 5'd3;
        exe_dest = 5'd7; exe_wb_en = 1'b1;
        #1;
        check("imm_src2_ignored", hazard_detected, 0);
        cycle();
        source1 = 5'd7;
        #1;
`ifdef HAZARD_FORWARDING_EN
        check("imm_src1_fwd", hazard_detected, 0);
`else
        check("imm_src1_hazard", hazard_detected, 1);
`endif
        cycle();

        // Register 0 never matches
        idle();
        exe_dest = '0; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
        mem_wb_en = 1'b1; source1 = '0; branch_comm = BR_BEZ;
        #1;
        check("reg0_no_hazard", hazard_detected, 0);
        cycle();

        // Branch flush, then flush suppressed by memory freeze
        reset_cycle();
        br_taken = 1'b1;
        #1;
        check("br_flush", flush_ifid, 1);
        cycle();
        br_taken = 1'b0;
        #1;
        check("br_flush_one_cycle", flush_ifid, 0);
        check("br_flush_cnt", flush_count, 1);
        br_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        check("br_flush_frozen", flush_ifid, 0);
        check("br_freeze_all", freeze_all, 1);
        cycle();
        br_taken = 1'b0; mem_ready = 1'b1;
        cycle();
        idle();
        check("br_flush_cnt_hold", flush_count, 1);

        // Memory wait of three cycles
        reset_cycle();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("memwait_freeze", freeze_all, 1);
            cycle();
        end
        mem_ready = 1'b1;
        #1;
        check("memwait_done_freeze", freeze_all, 0);
        cycle();
        idle();
        #1;
        check("memwait_stall_cnt", stall_cycles, 3);
        check("memwait_run_freeze", freeze_all, 0);
        check("memwait_no_timeout", mem_timeout, 0);

        // Timeout, stickiness, counter saturation, then reset
        reset_cycle();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            check("timeout_flag", mem_timeout, (k >= MT) ? 1 : 0);
        end
        check("stall_saturated", stall_cycles, CMAX);
        mem_req = 1'b0;
        #1;
        check("timeout_freeze_all", freeze_all, 1);
        cycle();
        check("timeout_sticky", mem_timeout, 1);
        reset_cycle();
        #1;
        check("post_rst_timeout", mem_timeout, 0);
        check("post_rst_freeze_all", freeze_all, 0);
        check("post_rst_stall_cnt", stall_cycles, 0);
        check("post_rst_flush_cnt", flush_count, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            source1       = REG_LENGTH'($urandom_range(0, 7));
            src2_reg_file = REG_LENGTH'($urandom_range(0, 7));
            exe_dest      = REG_LENGTH'($urandom_range(0, 7));
            mem_dest      = REG_LENGTH'($urandom_range(0, 7));
            is_imm        = 1'($urandom_range(0, 1));
            st_or_bne     = 1'($urandom_range(0, 1));
            branch_comm   = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            br_taken      = 1'($urandom_range(0, 1));
            exe_wb_en     = 1'($urandom_range(0, 1));
            exe_mem_read  = 1'($urandom_range(0, 3) == 0);
            mem_wb_en     = 1'($urandom_range(0, 1));
            mem_req       = 1'($urandom_range(0, 9) < 3);
            mem_ready     = 1'($urandom_range(0, 9) < 6);
            reset         = 1'($urandom_range(0, 199) != 0);
            cycle();
        end
        reset = 1'b1;
        idle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_hazard_stall_ctrl
`default_nettype wire

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline sequencing controller for the decode stage. It compares decode-stage source registers against in-flight EXE/MEM destinations and drives `hazard_detected` into the decode control unit. It also freezes the front end, flushes IF/ID on taken branches, and holds the whole pipe while the data memory is not ready. Saturating performance counters and a memory-wait timeout provide debug visibility. It sits beside the decode stage and takes inputs from the decode, EXE and MEM pipeline registers.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255: number of consecutive `MEM_WAIT` cycles before entering `TIMEOUT`.
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `source1` in `REG_LENGTH`: decode src1, instr[20:16].
- `src2_reg_file` in `REG_LENGTH`: decode src2.
- `is_imm` in 1: decode instruction uses an immediate.
- `st_or_bne` in 1: store or BNE, so src2 is read.
- `branch_comm` in 2: decode branch command; 0 means no branch.
- `br_taken` in 1: branch resolved taken in decode.
- `exe_dest` in `REG_LENGTH`, `exe_wb_en` in 1, `exe_mem_read` in 1: EXE-stage destination info.
- `mem_dest` in `REG_LENGTH`, `mem_wb_en` in 1: MEM-stage destination info.
- `mem_req` in 1: MEM stage is performing a load or store this cycle.
- `mem_ready` in 1: data memory completes the access this cycle.
- `hazard_detected` out 1: to the decode control unit; zeroes control outputs (inserts a bubble).
- `freeze_front` out 1: hold PC and IF/ID.
- `flush_ifid` out 1: load a NOP into IF/ID at the next edge.
- `freeze_all` out 1: hold every pipeline register.
- `mem_timeout` out 1: sticky error flag.
- `stall_cycles` out `CNT_W`: saturating count of cycles with `hazard_detected` or `freeze_all`.
- `flush_count` out `CNT_W`: saturating count of flushes.

## Operation
- src2 is "used" when `!is_imm || st_or_bne`. src1 is always used.
- Register 0 never matches any destination.
- Hazard match:
  - Without the `FORWARDING_EN` feature: hazard if any used source equals `exe_dest` with `exe_wb_en`, or equals `mem_dest` with `mem_wb_en`.
  - With the `FORWARDING_EN` feature, any of the following is a hazard:
    - A used source equals `exe_dest` while `exe_mem_read` is asserted (load-use).
    - `branch_comm != 0` and a used source equals `exe_dest` while `exe_wb_en` is asserted. Branches compare register values in decode, so they cannot use forwarding.
- `freeze_front = hazard_detected`.
- `flush_ifid = br_taken && !freeze_all && !hazard_detected`.
- FSM states: `RUN`, `MEM_WAIT`, `TIMEOUT`.
  - `RUN`: if `mem_req && !mem_ready`, go to `MEM_WAIT` and clear the wait counter.
  - `MEM_WAIT`: on `mem_ready`, go to `RUN`. Otherwise increment the wait counter; when it reaches `MEM_TIMEOUT-1`, go to `TIMEOUT`.
  - `TIMEOUT`: terminal until reset. `mem_timeout` = 1, `freeze_all` = 1.
- `freeze_all = (mem_req && !mem_ready) || state==TIMEOUT`. It is combinational, so the freeze takes effect in the first wait cycle.
- Priority: `freeze_all` forces `hazard_detected`, `freeze_front` and `flush_ifid` to 0. The whole pipe holds, so no bubble is inserted.
- Counters: increment by 1 per qualifying cycle and saturate at all-ones; they do not wrap.

## Timing
- Outputs after reset: `hazard_detected`, `freeze_front`, `flush_ifid`, `freeze_all` = 0 (given `mem_req` = 0); `mem_timeout` = 0; counters = 0; state = `RUN`.
- Reset has priority over every event, including mid-`MEM_WAIT` or `TIMEOUT`.
- Hazard and flush outputs: zero latency, combinational from the same-cycle inputs.
- A load-use hazard lasts exactly 1 cycle, because the load then advances to MEM.
- Without the `FORWARDING_EN` feature, a RAW hazard on EXE lasts 2 cycles.
- A `mem_ready` arriving in the same cycle as `mem_req` produces zero wait cycles.
- A `mem_ready` arriving in the same cycle the counter hits its limit wins: the FSM returns to `RUN`.
- `mem_timeout` and the counters are registered; they update on the edge after the qualifying cycle.

## Configuration
- `HAZARD_FORWARDING_EN`:
  - Defined: forwarding-aware rules (load-use hazards, plus branch-operand hazards on EXE only).
  - Undefined: full EXE/MEM RAW stall with no forwarding assumed.

## Structure
- `defines.v` holds:
  - `REG_LENGTH`.
  - `branch_comm` encodings.
  - FSM state encodings `HSC_RUN`, `HSC_MEM_WAIT`, `HSC_TIMEOUT`.
- Sub-module `reg_match_unit` (combinational): takes the sources, use flags and one destination/enable pair, and returns a match. It is instantiated once per compared stage.

## Test plan
- Load-use: EXE holds a load to r5 with `exe_mem_read` = 1; decode has `source1` = 5 with forwarding enabled. Require `hazard_detected` = 1 and `freeze_front` = 1 for 1 cycle, and `stall_cycles` = 1.
- Immediate form: decode has `is_imm` = 1, `st_or_bne` = 0, `src2_reg_file` = 7; EXE has `exe_dest` = 7 with `exe_wb_en` = 1. Require no hazard without forwarding, and `hazard_detected` = 1 when `source1` = 7.
- Register 0: EXE has `exe_dest` = 0 with `exe_wb_en` = 1; decode has `source1` = 0. Require `hazard_detected` = 0.
- Branch flush: `br_taken` = 1 with no hazard. Require `flush_ifid` = 1 for one cycle and `flush_count` = 1. Then repeat with `mem_req` = 1 and `mem_ready` = 0, and require `flush_ifid` = 0.
- Memory wait: `mem_ready` low for 3 cycles, then high. Require `freeze_all` = 1 for 3 cycles, a return to `RUN`, and `stall_cycles` = 3.
- Timeout and reset: `MEM_TIMEOUT` = 4 with `mem_ready` held 0. Require `mem_timeout` = 1 from the fifth cycle and sticky. A single low cycle on `reset` clears everything to the reset values.
